mm_responder: RTL and testbench
===============================

// Module: mm_responder
// PURPOSE
//  Memory-bus responder (target side) for the cpu16 address/data/wren/q bus; drop-in replacement for the MM RAM.
//  Word RAM serves the low address range; the top 16 words form an I/O page (LED, scratch, timer/IRQ).
//  Read data is registered with 1-cycle latency, so the cpu16 control FSM timing is unchanged.
// PARAMETERS
//  BW       16       data word width
//  AW       9        address width (512 words)
//  IO_BASE  9'h1F0   first I/O page address; RAM occupies 0..IO_BASE-1; I/O page is IO_BASE..IO_BASE+15
// PORTS
//  clk      in   1    system clock, rising edge
//  rst      in   1    synchronous reset, active-low
//  address  in   AW   word address from CPU
//  data     in   BW   write data from CPU
//  wren     in   1    write enable; write occurs at the rising edge where wren=1
//  q        out  BW   registered read data for the address presented in the previous cycle
//  led_out  out  BW   LED register contents
//  irq      out  1    registered interrupt request, level, active-high
// BEHAVIOUR
//  - Reset (rst=0 at an edge): q=0, led_out=0, irq=0, SCRATCH=0, CNT=0, CMP=16'hFFFF, CTRL=0, STATUS=0. RAM contents are not reset.
//  - Read: address A sampled at edge n -> q=mem[A] after edge n+1. q updates every cycle; there is no read strobe.
//  - Write: wren=1 at edge n updates the target at edge n. Read-during-write to the same address returns the OLD value.
//  - Write to a RAM address >= IO_BASE is impossible by decode; an I/O write never touches RAM.
//  - I/O map, as offset from IO_BASE:
//    0 LED      RW; drives led_out.
//    1 CNT      RW; a write loads the counter, and the write wins over a same-cycle increment.
//    2 CMP      RW; compare value.
//    3 CTRL     RW; bit0=EN, bit1=RELOAD, bit2=IRQ_EN; bits[15:3] read 0.
//    4 STATUS   bit0=MATCH, write-1-to-clear; reads return {15'b0,MATCH}.
//    5 SCRATCH  RW.
//    6..15      read 0; writes ignored.
//  - Timer counting: while EN=1, CNT increments by 1 every cycle, mod 2^BW (wraps FFFF->0000).
//  - Match event: the cycle CNT==CMP with EN=1 sets MATCH at the next edge.
//    - RELOAD=1: CNT reloads to 0 instead of incrementing.
//    - RELOAD=0: CNT holds its value and EN clears (one-shot).
//  - MATCH set and a W1C write in the same cycle: set wins, so MATCH stays 1.
//  - irq is registered as MATCH & IRQ_EN, so it lags MATCH by 1 cycle. Clearing IRQ_EN or MATCH drops irq 1 cycle later.
//  - Reset asserted mid-operation overrides all writes and counting in that cycle.
// CONFIGURATION
//  MMIO_TIMER_EN defined:     CNT/CMP/CTRL/STATUS and irq behave as above.
//  MMIO_TIMER_EN not defined: offsets 1..4 read 0, writes to them are ignored, irq is tied to 0, and no timer flops are built.
//    LED, SCRATCH and RAM are unaffected.
// STRUCTURE
//  Package cpu16_pkg:
//   - I/O offsets: OFS_LED, OFS_CNT, OFS_CMP, OFS_CTRL, OFS_STATUS, OFS_SCRATCH.
//   - CTRL bit indices: CTRL_EN, CTRL_RELOAD, CTRL_IRQEN.
//   - Reset constant CMP_RST=16'hFFFF.
//  Sub-module mm_timer:
//   - Holds CNT/CMP/CTRL/STATUS and irq.
//   - Has a register write port and a read mux output.
//   - Instantiated only under MMIO_TIMER_EN.
//  Top level: RAM array, address decode and q register.
// TESTING
//  1. Write 16'h1234 to RAM address 5; present address 5 -> q=16'h1234 one cycle later. q=0 immediately after reset.
//  2. RAM address 7 holds 16'hAAAA; write 16'h5555 to address 7 while reading it -> q=16'hAAAA, and the next read gives 16'h5555.
//  3. Write 16'h00F0 to 0x1F0 -> led_out=16'h00F0. Read 0x1F9 -> q=0.
//     Assert rst=0 for 1 cycle -> led_out=0 and q=0.
//  4. Timer one-shot: CMP=3, CNT=0, CTRL=3'b101 -> MATCH=1 after the 4th enabled edge, irq=1 one cycle later, EN cleared, CNT holds 3.
//  5. Timer auto-reload: CMP=2, CTRL=3'b011 -> CNT sequence 0,1,2,0,1,2. Write STATUS=1 on the match cycle -> MATCH stays 1.
//     Write STATUS=1 on a non-match cycle -> MATCH=0.
//  6. Build without MMIO_TIMER_EN: write CTRL=7 and CMP=0 -> reads of 0x1F1..0x1F4 return 0, and irq stays 0 for 100 cycles.

Source files
------------

// File: rtl/cpu16_pkg.sv
// Shared constants for the cpu16 memory-mapped responder: bus widths,
// I/O page offsets, timer CTRL bit positions and reset values.
package cpu16_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned IO_OFS_W = 4;
  localparam int unsigned CTRL_W   = 3;

  // I/O page offsets relative to IO_BASE
  localparam logic [IO_OFS_W-1:0] OFS_LED     = 4'd0;
  localparam logic [IO_OFS_W-1:0] OFS_CNT     = 4'd1;
  localparam logic [IO_OFS_W-1:0] OFS_CMP     = 4'd2;
  localparam logic [IO_OFS_W-1:0] OFS_CTRL    = 4'd3;
  localparam logic [IO_OFS_W-1:0] OFS_STATUS  = 4'd4;
  localparam logic [IO_OFS_W-1:0] OFS_SCRATCH = 4'd5;

  // CTRL register bit indices
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;
  localparam int unsigned CTRL_IRQEN  = 2;

  localparam logic [15:0] CMP_RST = 16'hFFFF;

endpackage

// File: rtl/mm_timer.sv
// Timer/IRQ block of the I/O page: CNT, CMP, CTRL, STATUS(MATCH) and a
// registered irq. Only built when MMIO_TIMER_EN is defined.
module mm_timer
  import cpu16_pkg::*;
#(
  parameter int unsigned BW = DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr_en,
  input  logic [IO_OFS_W-1:0] i_wr_ofs,
  input  logic [BW-1:0]       i_wr_data,
  input  logic [IO_OFS_W-1:0] i_rd_ofs,
  output logic [BW-1:0]       o_rd_data_c,
  output logic                o_irq
);

  logic [BW-1:0]     r_cnt;
  logic [BW-1:0]     r_cmp;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_match;
  logic              r_irq;

  logic [BW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     w_cmp_nxt;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic              w_match_nxt;
  logic              w_en;
  logic              w_hit;

  assign w_en  = r_ctrl[CTRL_EN];
  assign w_hit = w_en && (r_cnt == r_cmp);

  // Next-state: register writes take priority over counting/reload/one-shot stop
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_cmp_nxt   = r_cmp;
    w_ctrl_nxt  = r_ctrl;
    w_match_nxt = r_match;

    if (i_wr_en && (i_wr_ofs == OFS_CNT)) begin
      w_cnt_nxt = i_wr_data;
    end else if (w_hit) begin
      w_cnt_nxt = r_ctrl[CTRL_RELOAD] ? '0 : r_cnt;
    end else if (w_en) begin
      w_cnt_nxt = r_cnt + BW'(1);
    end

    if (i_wr_en && (i_wr_ofs == OFS_CMP)) begin
      w_cmp_nxt = i_wr_data;
    end

    if (i_wr_en && (i_wr_ofs == OFS_CTRL)) begin
      w_ctrl_nxt = i_wr_data[CTRL_W-1:0];
    end else if (w_hit && !r_ctrl[CTRL_RELOAD]) begin
      w_ctrl_nxt[CTRL_EN] = 1'b0;
    end

    // A match in the same cycle as a W1C keeps MATCH set
    if (w_hit) begin
      w_match_nxt = 1'b1;
    end else if (i_wr_en && (i_wr_ofs == OFS_STATUS) && i_wr_data[0]) begin
      w_match_nxt = 1'b0;
    end
  end

  // Timer registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_cmp   <= BW'(CMP_RST);
      r_ctrl  <= '0;
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_cmp   <= w_cmp_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_match <= w_match_nxt;
      r_irq   <= r_match & r_ctrl[CTRL_IRQEN];
    end
  end

  // Read mux for the timer offsets
  always_comb begin
    o_rd_data_c = '0;
    case (i_rd_ofs)
      OFS_CNT:    o_rd_data_c = r_cnt;
      OFS_CMP:    o_rd_data_c = r_cmp;
      OFS_CTRL:   o_rd_data_c = BW'(r_ctrl);
      OFS_STATUS: o_rd_data_c = BW'(r_match);
      default:    o_rd_data_c = '0;
    endcase
  end

  assign o_irq = r_irq;

endmodule

// File: rtl/mm_responder.sv
// cpu16 memory-bus responder: word RAM below IO_BASE, 16-word I/O page
// (LED, SCRATCH, optional timer) above it, 1-cycle registered read data.
// Optional timer block is enabled by defining MMIO_TIMER_EN.
module mm_responder
  import cpu16_pkg::*;
#(
  parameter int unsigned    BW      = DATA_W,
  parameter int unsigned    AW      = ADDR_W,
  parameter logic [AW-1:0]  IO_BASE = AW'(9'h1F0)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] address,
  input  logic [BW-1:0] data,
  input  logic          wren,
  output logic [BW-1:0] q,
  output logic [BW-1:0] led_out,
  output logic          irq
);

  localparam int unsigned RAM_WORDS = 32'(IO_BASE);

  logic [BW-1:0]       r_mem [RAM_WORDS];
  logic [BW-1:0]       r_q;
  logic [BW-1:0]       r_led;
  logic [BW-1:0]       r_scratch;

  logic                w_is_io;
  logic [IO_OFS_W-1:0] w_io_ofs;
  logic                w_ram_we;
  logic                w_io_we;
  logic [BW-1:0]       w_rd_data;

  assign w_is_io  = (address >= IO_BASE);
  assign w_io_ofs = IO_OFS_W'(address - IO_BASE);
  // Reset blocks every write, including RAM
  assign w_ram_we = rst && wren && !w_is_io;
  assign w_io_we  = rst && wren && w_is_io;

`ifdef MMIO_TIMER_EN
  logic [BW-1:0] w_tmr_rd;

  mm_timer #(
    .BW(BW)
  ) u_timer (
    .i_clk       (clk),
    .i_rst_n     (rst),
    .i_wr_en     (w_io_we),
    .i_wr_ofs    (w_io_ofs),
    .i_wr_data   (data),
    .i_rd_ofs    (w_io_ofs),
    .o_rd_data_c (w_tmr_rd),
    .o_irq       (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // RAM write port; contents are not reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[address] <= data;
    end
  end

  // LED and SCRATCH registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_led     <= '0;
      r_scratch <= '0;
    end else if (w_io_we) begin
      if (w_io_ofs == OFS_LED)     r_led     <= data;
      if (w_io_ofs == OFS_SCRATCH) r_scratch <= data;
    end
  end

  // Read data select for the current address
  always_comb begin
    w_rd_data = '0;
    if (!w_is_io) begin
      w_rd_data = r_mem[address];
    end else begin
      case (w_io_ofs)
        OFS_LED:     w_rd_data = r_led;
        OFS_SCRATCH: w_rd_data = r_scratch;
`ifdef MMIO_TIMER_EN
        OFS_CNT, OFS_CMP, OFS_CTRL, OFS_STATUS: w_rd_data = w_tmr_rd;
`endif
        default:     w_rd_data = '0;
      endcase
    end
  end

  // Registered read data; pre-edge values give read-old-on-write
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else begin
      r_q <= w_rd_data;
    end
  end

  assign q       = r_q;
  assign led_out = r_led;

endmodule

// File: tb/tb_mm_responder.sv
// Directed self-checking bench for mm_responder (both timer builds).
module tb_mm_responder;

  logic        clk;
  logic        rst;
  logic [8:0]  address;
  logic [15:0] data;
  logic        wren;
  logic [15:0] q;
  logic [15:0] led_out;
  logic        irq;

  int checks;
  int failures;

  mm_responder dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .led_out (led_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    address = a;
    data    = d;
    wren    = 1'b1;
    step();
    wren    = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a);
    address = a;
    wren    = 1'b0;
    step();
  endtask

  logic [15:0] exp_seq [6];

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    address  = '0;
    data     = '0;
    wren     = 1'b0;
    step();
    step();
    check("reset_q", q, 16'h0000);
    check("reset_led", led_out, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);
    rst = 1'b1;

    // RAM write then read
    wr(9'd5, 16'h1234);
    rd(9'd5);
    check("ram_rd5", q, 16'h1234);

    // Read-during-write returns the old value
    wr(9'd7, 16'hAAAA);
    address = 9'd7;
    data    = 16'h5555;
    wren    = 1'b1;
    step();
    check("rdw_old", q, 16'hAAAA);
    wren = 1'b0;
    step();
    check("rdw_new", q, 16'h5555);

    // Last RAM word just below the I/O page
    wr(9'h1EF, 16'h0BAD);
    rd(9'h1EF);
    check("ram_top", q, 16'h0BAD);

    // LED, SCRATCH, unused I/O offset
    wr(9'h1F0, 16'h00F0);
    check("led_wr", led_out, 16'h00F0);
    rd(9'h1F0);
    check("led_rd", q, 16'h00F0);
    rd(9'h1F9);
    check("io_unused", q, 16'h0000);
    wr(9'h1F9, 16'hFFFF);
    rd(9'h1F9);
    check("io_unused_wr", q, 16'h0000);
    wr(9'h1F5, 16'hBEEF);
    rd(9'h1F5);
    check("scratch_rd", q, 16'hBEEF);

    // Mid-operation reset overrides a same-cycle LED write
    address = 9'h1F0;
    data    = 16'h7777;
    wren    = 1'b1;
    rst     = 1'b0;
    step();
    wren = 1'b0;
    rst  = 1'b1;
    check("rst_led", led_out, 16'h0000);
    check("rst_q", q, 16'h0000);
    rd(9'h1F5);
    check("rst_scratch", q, 16'h0000);
    rd(9'd5);
    check("ram_kept", q, 16'h1234);

`ifdef MMIO_TIMER_EN
    rd(9'h1F2);
    check("cmp_reset", q, 16'hFFFF);

    // One-shot with IRQ
    wr(9'h1F2, 16'd3);
    wr(9'h1F1, 16'd0);
    wr(9'h1F3, 16'h0005);
    address = 9'h1F4;
    for (int i = 0; i < 4; i++) step();
    check("os_irq_lag", {15'b0, irq}, 16'h0000);
    step();
    check("os_match", q, 16'h0001);
    check("os_irq", {15'b0, irq}, 16'h0001);
    rd(9'h1F1);
    check("os_cnt_hold", q, 16'd3);
    rd(9'h1F3);
    check("os_en_clr", q, 16'h0004);
    step();
    step();
    rd(9'h1F1);
    check("os_cnt_still", q, 16'd3);
    wr(9'h1F4, 16'h0001);
    check("w1c_irq_lag", {15'b0, irq}, 16'h0001);
    step();
    check("w1c_irq_drop", {15'b0, irq}, 16'h0000);
    rd(9'h1F4);
    check("w1c_status", q, 16'h0000);

    // Auto-reload, IRQ disabled
    exp_seq[0] = 16'd0; exp_seq[1] = 16'd1; exp_seq[2] = 16'd2;
    exp_seq[3] = 16'd0; exp_seq[4] = 16'd1; exp_seq[5] = 16'd2;
    wr(9'h1F2, 16'd2);
    wr(9'h1F1, 16'd0);
    wr(9'h1F3, 16'h0003);
    address = 9'h1F1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("reload_seq%0d", i), q, exp_seq[i]);
    end
    // CNT is 0 now: clear on a non-match cycle
    wr(9'h1F4, 16'h0001);
    rd(9'h1F4);
    check("w1c_nomatch", q, 16'h0000);
    // CNT is 2 now: clear on the match cycle, set wins
    wr(9'h1F4, 16'h0001);
    rd(9'h1F4);
    check("w1c_match_set", q, 16'h0001);
    check("reload_noirq", {15'b0, irq}, 16'h0000);
    // CNT write wins over increment
    wr(9'h1F1, 16'h0100);
    rd(9'h1F1);
    check("cnt_wr_wins", q, 16'h0100);
    wr(9'h1F3, 16'h0000);

    // Wrap FFFF -> 0000
    wr(9'h1F2, 16'd5);
    wr(9'h1F1, 16'hFFFE);
    wr(9'h1F3, 16'h0001);
    address = 9'h1F1;
    step();
    check("wrap_fffe", q, 16'hFFFE);
    step();
    check("wrap_ffff", q, 16'hFFFF);
    step();
    check("wrap_0000", q, 16'h0000);

    // Reset mid-count restores timer defaults
    rst = 1'b0;
    step();
    rst = 1'b1;
    rd(9'h1F3);
    check("rst_ctrl", q, 16'h0000);
    rd(9'h1F2);
    check("rst_cmp", q, 16'hFFFF);
    rd(9'h1F4);
    check("rst_status", q, 16'h0000);
`else
    // Timer absent: offsets 1..4 inert, irq tied low
    wr(9'h1F3, 16'h0007);
    wr(9'h1F2, 16'h0000);
    wr(9'h1F1, 16'h0055);
    for (int a = 1; a <= 4; a++) begin
      rd(9'(9'h1F0 + a));
      check($sformatf("notmr_rd%0d", a), q, 16'h0000);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      check("notmr_irq", {15'b0, irq}, 16'h0000);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
